picc_tx_scheduler: RTL and testbench
====================================

PICC_TX_SCHEDULER -- requirements
Module: picc_tx_scheduler

Interface
REQ-001 The block SHALL have parameter FDT_CYCLES, default 11720, guard delay in clk_in cycles from accept to trigger (legal 1..2^20-1).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, maximum clk_in cycles from trigger to done.
REQ-003 clk_in  input  1  system clock (135.6 MHz); the block SHALL use one clock only.
REQ-004 rst_in  input  1  reset, asynchronous, active-high.
REQ-005 req0_valid_in / req1_valid_in  input  1 each  frame request from requester 0 / 1.
REQ-006 req0_data_in / req1_data_in  input  40 each  frame payload, byte 0 in bits [7:0].
REQ-007 req0_num_bytes_in / req1_num_bytes_in  input  3 each  payload length in bytes.
REQ-008 req0_ready_out / req1_ready_out  output  1 each  accept strobe; transfer occurs when valid and ready are both high.
REQ-009 picc_data_out  output  40  payload to the PICC transmitter.
REQ-010 picc_num_bytes_out  output  3  length to the PICC transmitter.
REQ-011 picc_trigger_out  output  1  one-cycle start pulse to the PICC transmitter.
REQ-012 picc_busy_in / picc_done_in  input  1 each  transmitter status from the divided-clock domain, asynchronous to clk_in.
REQ-013 grant_id_out  output  1  requester that owns the current frame.
REQ-014 active_out  output  1  high in any state other than IDLE.
REQ-015 err_len_out / err_timeout_out  output  1 each  one-cycle error pulses.

Function
REQ-016 States SHALL be IDLE, GUARD, TRIG, WAIT_BUSY and WAIT_DONE.
REQ-017 picc_busy_in and picc_done_in SHALL each pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized copies.
REQ-018 In IDLE, reqN_ready_out SHALL be combinationally high only for the requester selected by the arbiter; it SHALL be low in all other states.
REQ-019 Arbitration SHALL be round-robin:
- if only one requester is valid, that requester wins;
- if both are valid, the requester not granted last wins;
- the pointer SHALL favour req0 after reset.
REQ-020 On accept, the block SHALL latch data, length and grant_id into picc_data_out, picc_num_bytes_out and grant_id_out, hold them stable until re-entry to IDLE, and toggle the pointer.
REQ-021 Accepted length 0 or >5:
- err_len_out SHALL pulse on the next cycle;
- the FSM SHALL stay in IDLE and no trigger SHALL occur;
- the pointer SHALL still advance.
REQ-022 Legal accept SHALL enter GUARD next cycle; GUARD SHALL last exactly FDT_CYCLES cycles and then go to TRIG.
REQ-023 TRIG SHALL last one cycle with picc_trigger_out=1, then go to WAIT_BUSY; the trigger is therefore high on cycle FDT_CYCLES+1 after the accept cycle.
REQ-024 WAIT_BUSY SHALL go to WAIT_DONE when synchronized busy=1.
REQ-025 If synchronized done=1 is seen in WAIT_BUSY or WAIT_DONE, the FSM SHALL return to IDLE next cycle.
REQ-026 A timeout counter SHALL start at TRIG; if it reaches TIMEOUT_CYCLES before done, err_timeout_out SHALL pulse for one cycle and the FSM SHALL go to IDLE.
REQ-027 If done and timeout occur in the same cycle, done SHALL win and no error SHALL be flagged.
REQ-028 Requests arriving outside IDLE SHALL be held off (ready=0) and not dropped; the earliest new accept SHALL be the first IDLE cycle.
REQ-029 Counters SHALL saturate/clear on state exit and SHALL never wrap.

Reset
REQ-030 While rst_in=1, state, pointer, counters and synchronizers SHALL clear.
REQ-031 While rst_in=1, outputs SHALL be: picc_data_out=0, picc_num_bytes_out=0, trigger=0, ready=0, grant_id_out=0, active_out=0, error pulses=0.
REQ-032 Reset mid-frame SHALL abandon the frame immediately with no trigger or error pulse afterward.

Verification
REQ-033 FDT_CYCLES=4: req0 valid with data 40'h00_24_90_67_35, length 4 -> ready at cycle 0, trigger high at cycle 5 only; picc_data_out=40'h0024906735; after busy then done, active_out returns to 0.
REQ-034 Both requesters valid continuously -> grants alternate 0,1,0,1; each requester is ready only in IDLE.
REQ-035 req1 with length 0, then length 7 -> two err_len_out pulses, no trigger, active_out stays 0.
REQ-036 TIMEOUT_CYCLES=50, busy never asserted -> one err_timeout_out pulse 50 cycles after trigger, then IDLE, next request accepted.
REQ-037 rst_in asserted during GUARD, and separately during WAIT_DONE -> all outputs 0 immediately, no trigger after release until a new accept.
REQ-038 done and timeout coinciding in the same cycle -> IDLE with no err_timeout_out pulse.

Source files
------------

// File: rtl/picc_tx_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// picc_tx_scheduler
//
// Purpose:
//   Arbitrates between two frame requesters and schedules each accepted frame
//   onto the PICC transmitter. It waits the frame delay time (FDT) before
//   issuing a one-cycle trigger, then tracks the transmitter's busy/done status
//   with a timeout. Both status inputs come from an asynchronous clock domain
//   and are synchronised before use.
//
// Parameters:
//   FDT_CYCLES      guard delay, clk_in cycles from accept to trigger (1..2^20-1)
//   TIMEOUT_CYCLES  maximum clk_in cycles from trigger to done
//
// Ports:
//   clk_in, rst_in                 clock, asynchronous active-high reset
//   reqN_valid_in                  frame request from requester N (N = 0, 1)
//   reqN_data_in[39:0]             payload, byte 0 in bits [7:0]
//   reqN_num_bytes_in[2:0]         payload length in bytes (legal 1..5)
//   reqN_ready_out                 accept strobe (valid & ready = transfer)
//   picc_data_out[39:0]            latched payload to the transmitter
//   picc_num_bytes_out[2:0]        latched length to the transmitter
//   picc_trigger_out               one-cycle start pulse
//   picc_busy_in, picc_done_in     transmitter status (asynchronous)
//   grant_id_out                   requester owning the current frame
//   active_out                     high whenever the FSM is not IDLE
//   err_len_out, err_timeout_out   one-cycle error pulses
// -----------------------------------------------------------------------------
module picc_tx_scheduler #(
  parameter int unsigned FDT_CYCLES     = 11720,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req0_valid_in,
  input  logic [39:0] req0_data_in,
  input  logic [2:0]  req0_num_bytes_in,
  output logic        req0_ready_out,
  input  logic        req1_valid_in,
  input  logic [39:0] req1_data_in,
  input  logic [2:0]  req1_num_bytes_in,
  output logic        req1_ready_out,
  output logic [39:0] picc_data_out,
  output logic [2:0]  picc_num_bytes_out,
  output logic        picc_trigger_out,
  input  logic        picc_busy_in,
  input  logic        picc_done_in,
  output logic        grant_id_out,
  output logic        active_out,
  output logic        err_len_out,
  output logic        err_timeout_out
);

  localparam int unsigned GUARD_W = (FDT_CYCLES > 1) ? $clog2(FDT_CYCLES) : 1;
  localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Terminal counts. The guard counter holds 0..FDT_CYCLES-1, one value per
  // GUARD cycle. The timeout counter is 0 in TRIG and k on cycle k after it;
  // the timeout decision is taken at TIMEOUT_CYCLES-1 so that the registered
  // error pulse and the return to IDLE land exactly TIMEOUT_CYCLES after TRIG.
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(FDT_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GUARD,
    ST_TRIG,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_e;

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_busy_meta;
  logic               r_busy_sync;
  logic               r_done_meta;
  logic               r_done_sync;
  logic               r_ptr;
  logic [GUARD_W-1:0] r_guard_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic [39:0]        r_data;
  logic [2:0]         r_len;
  logic               r_gid;
  logic               r_err_len;
  logic               r_err_to;

  logic               w_sel;
  logic               w_accept;
  logic [39:0]        w_sel_data;
  logic [2:0]         w_sel_len;
  logic               w_len_ok;
  logic               w_timeout;

  // ---------------------------------------------------------------------------
  // Status synchronisers (two flops each)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, independent of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_busy_meta <= 1'b0;
      r_busy_sync <= 1'b0;
      r_done_meta <= 1'b0;
      r_done_sync <= 1'b0;
    end else begin
      r_busy_meta <= picc_busy_in;
      r_busy_sync <= r_busy_meta;
      r_done_meta <= picc_done_in;
      r_done_sync <= r_done_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter. r_ptr names the requester favoured on a tie; it is set
  // to the opposite of every winner so the last-granted side loses the next tie.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (req0_valid_in && req1_valid_in) w_sel = r_ptr;
    else                                w_sel = req1_valid_in;
  end

  assign w_accept   = (r_state == ST_IDLE) && (req0_valid_in || req1_valid_in);
  assign w_sel_data = w_sel ? req1_data_in : req0_data_in;
  assign w_sel_len  = w_sel ? req1_num_bytes_in : req0_num_bytes_in;
  assign w_len_ok   = (w_sel_len != 3'd0) && (w_sel_len <= 3'd5);

  // Ready is gated by reset because the FSM sits in IDLE while reset is held.
  assign req0_ready_out = !rst_in && (r_state == ST_IDLE) && req0_valid_in && !w_sel;
  assign req1_ready_out = !rst_in && (r_state == ST_IDLE) && req1_valid_in &&  w_sel;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_len_ok) w_state_nxt = ST_GUARD;
      end
      ST_GUARD: begin
        if (r_guard_cnt == GUARD_LAST) w_state_nxt = ST_TRIG;
      end
      ST_TRIG: begin
        w_state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY, ST_WAIT_DONE: begin
        // done is tested first so it wins over a coincident timeout
        if (r_done_sync) begin
          w_state_nxt = ST_IDLE;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_nxt = ST_IDLE;
          w_timeout   = 1'b1;
        end else if (r_state == ST_WAIT_BUSY && r_busy_sync) begin
          w_state_nxt = ST_WAIT_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters: each counts only in its own states and is held at zero elsewhere,
  // so it clears on state exit and never reaches a wrap point.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_guard_cnt <= '0;
      r_to_cnt    <= '0;
    end else begin
      if (r_state == ST_GUARD && r_guard_cnt != GUARD_LAST) r_guard_cnt <= r_guard_cnt + 1'b1;
      else                                                  r_guard_cnt <= '0;

      if ((r_state == ST_TRIG || r_state == ST_WAIT_BUSY || r_state == ST_WAIT_DONE)
          && r_to_cnt != TO_LAST)
        r_to_cnt <= r_to_cnt + 1'b1;
      else
        r_to_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame latch, arbitration pointer and error pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_data    <= '0;
      r_len     <= '0;
      r_gid     <= 1'b0;
      r_ptr     <= 1'b0;
      r_err_len <= 1'b0;
      r_err_to  <= 1'b0;
    end else begin
      // Illegal lengths are still accepted: the frame is latched and the
      // pointer advances, only the FSM refuses to leave IDLE.
      if (w_accept) begin
        r_data <= w_sel_data;
        r_len  <= w_sel_len;
        r_gid  <= w_sel;
        r_ptr  <= ~w_sel;
      end
      r_err_len <= w_accept && !w_len_ok;
      r_err_to  <= w_timeout;
    end
  end

  assign picc_data_out      = r_data;
  assign picc_num_bytes_out = r_len;
  assign grant_id_out       = r_gid;
  assign picc_trigger_out   = (r_state == ST_TRIG);
  assign active_out         = (r_state != ST_IDLE);
  assign err_len_out        = r_err_len;
  assign err_timeout_out    = r_err_to;

endmodule

// File: tb/tb_picc_tx_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_picc_tx_scheduler
//
// Purpose:
//   Self-checking bench for picc_tx_scheduler with FDT_CYCLES=4 and
//   TIMEOUT_CYCLES=50. A transaction-level model predicts, for every request,
//   which requester wins and on which cycle the trigger or error pulse must
//   appear; those predictions go into a scoreboard queue that an independent
//   monitor drains whenever the DUT raises trigger/err_len/err_timeout.
// -----------------------------------------------------------------------------
module tb_picc_tx_scheduler;

  localparam int FDT = 4;
  localparam int TMO = 50;

  typedef enum logic [1:0] {EV_TRIG, EV_ERR_LEN, EV_ERR_TO} ev_kind_e;

  typedef struct {
    ev_kind_e    kind;
    int          cyc;
    logic [39:0] data;
    logic [2:0]  len;
    logic        gid;
  } ev_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        req0_valid_in = 1'b0;
  logic [39:0] req0_data_in = '0;
  logic [2:0]  req0_num_bytes_in = '0;
  logic        req0_ready_out;
  logic        req1_valid_in = 1'b0;
  logic [39:0] req1_data_in = '0;
  logic [2:0]  req1_num_bytes_in = '0;
  logic        req1_ready_out;
  logic [39:0] picc_data_out;
  logic [2:0]  picc_num_bytes_out;
  logic        picc_trigger_out;
  logic        picc_busy_in = 1'b0;
  logic        picc_done_in = 1'b0;
  logic        grant_id_out;
  logic        active_out;
  logic        err_len_out;
  logic        err_timeout_out;

  picc_tx_scheduler #(
    .FDT_CYCLES     (FDT),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .req0_valid_in      (req0_valid_in),
    .req0_data_in       (req0_data_in),
    .req0_num_bytes_in  (req0_num_bytes_in),
    .req0_ready_out     (req0_ready_out),
    .req1_valid_in      (req1_valid_in),
    .req1_data_in       (req1_data_in),
    .req1_num_bytes_in  (req1_num_bytes_in),
    .req1_ready_out     (req1_ready_out),
    .picc_data_out      (picc_data_out),
    .picc_num_bytes_out (picc_num_bytes_out),
    .picc_trigger_out   (picc_trigger_out),
    .picc_busy_in       (picc_busy_in),
    .picc_done_in       (picc_done_in),
    .grant_id_out       (grant_id_out),
    .active_out         (active_out),
    .err_len_out        (err_len_out),
    .err_timeout_out    (err_timeout_out)
  );

  always #5 clk_in = ~clk_in;

  // Cycle number: updated at each rising edge, stable for the rest of the cycle.
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  ev_t         exp_q[$];
  logic        last_gid = 1'b1;     // so that req0 wins the first tie
  logic        pend[2]  = '{1'b0, 1'b0};
  logic [39:0] mdl_data[2];
  logic [2:0]  mdl_len[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops one expected event per observed pulse
  // ---------------------------------------------------------------------------
  task automatic check_event(input ev_kind_e k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected no event", k, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind",  k,            e.kind);
      check("event_cycle", cyc,          e.cyc);
      check("event_grant", grant_id_out, e.gid);
      if (k == EV_TRIG) begin
        check("trig_data", picc_data_out,      e.data);
        check("trig_len",  picc_num_bytes_out, e.len);
      end
    end
  endtask

  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (picc_trigger_out) check_event(EV_TRIG);
      if (err_len_out)      check_event(EV_ERR_LEN);
      if (err_timeout_out)  check_event(EV_ERR_TO);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Advance to just after the rising edge that starts cycle c.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic pulse_busy();
    picc_busy_in = 1'b1;
    goto(cyc + 1);
    picc_busy_in = 1'b0;
  endtask

  task automatic pulse_done();
    picc_done_in = 1'b1;
    goto(cyc + 1);
    picc_done_in = 1'b0;
  endtask

  function automatic logic [39:0] rand_data();
    return {8'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [2:0] rand_len();
    if ($urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 2))
        0:       return 3'd0;
        1:       return 3'd6;
        default: return 3'd7;
      endcase
    end
    return 3'($urandom_range(1, 5));
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},   picc_data_out,      40'd0);
    check({tag, "_len"},    picc_num_bytes_out, 3'd0);
    check({tag, "_trig"},   picc_trigger_out,   1'b0);
    check({tag, "_ready0"}, req0_ready_out,     1'b0);
    check({tag, "_ready1"}, req1_ready_out,     1'b0);
    check({tag, "_gid"},    grant_id_out,       1'b0);
    check({tag, "_active"}, active_out,         1'b0);
    check({tag, "_errlen"}, err_len_out,        1'b0);
    check({tag, "_errto"},  err_timeout_out,    1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // One request round, started in a cycle where the DUT should be IDLE.
  // A requester that loses arbitration keeps its valid and payload asserted
  // (held off) and is served in a later round.
  // mode: 0 busy then done, 1 done without busy, 2 timeout,
  //       3 done coincides with timeout, 4 done one cycle too late.
  // Returns just after the edge that starts the next IDLE cycle.
  // ---------------------------------------------------------------------------
  task automatic round(input logic want0, input logic want1,
                       input logic [39:0] d0, input logic [2:0] l0,
                       input logic [39:0] d1, input logic [2:0] l1,
                       input int mode);
    int         c, t, k, idle, w;
    logic [2:0] wl;
    if (want0 && !pend[0]) begin
      pend[0] = 1'b1; mdl_data[0] = d0; mdl_len[0] = l0;
      req0_valid_in = 1'b1; req0_data_in = d0; req0_num_bytes_in = l0;
    end
    if (want1 && !pend[1]) begin
      pend[1] = 1'b1; mdl_data[1] = d1; mdl_len[1] = l1;
      req1_valid_in = 1'b1; req1_data_in = d1; req1_num_bytes_in = l1;
    end
    if (pend[0] && pend[1]) w = last_gid ? 0 : 1;
    else                    w = pend[1] ? 1 : 0;

    c = cyc;
    @(negedge clk_in);
    check("ready0_idle", req0_ready_out, w == 0);
    check("ready1_idle", req1_ready_out, w == 1);
    check("active_idle", active_out,     1'b0);
    goto(c + 1);
    if (w == 0) req0_valid_in = 1'b0;
    else        req1_valid_in = 1'b0;
    pend[w]  = 1'b0;
    last_gid = 1'(w);
    wl       = mdl_len[w];

    if (wl == 3'd0 || wl > 3'd5) begin
      exp_q.push_back('{kind: EV_ERR_LEN, cyc: c + 1, data: mdl_data[w], len: wl, gid: 1'(w)});
      return;
    end

    t = c + FDT + 1;
    exp_q.push_back('{kind: EV_TRIG, cyc: t, data: mdl_data[w], len: wl, gid: 1'(w)});
    @(negedge clk_in);
    check("active_after_accept", active_out,     1'b1);
    check("ready0_held_off",     req0_ready_out, 1'b0);
    check("ready1_held_off",     req1_ready_out, 1'b0);

    // A status pulse driven in cycle k is seen synchronised in k+2 and the
    // FSM is back in IDLE in k+3.
    case (mode)
      0: begin
        goto(t + $urandom_range(1, 5));
        pulse_busy();
        k = cyc + $urandom_range(0, 9);
        goto(k);
        pulse_done();
        idle = k + 3;
      end
      1: begin
        k = t + $urandom_range(1, 10);
        goto(k);
        pulse_done();
        idle = k + 3;
      end
      2: begin
        exp_q.push_back('{kind: EV_ERR_TO, cyc: t + TMO, data: mdl_data[w], len: wl, gid: 1'(w)});
        idle = t + TMO;
      end
      3: begin
        k = t + TMO - 3;
        goto(k);
        pulse_done();
        idle = t + TMO;
      end
      default: begin
        k = t + TMO - 2;
        exp_q.push_back('{kind: EV_ERR_TO, cyc: t + TMO, data: mdl_data[w], len: wl, gid: 1'(w)});
        goto(k);
        pulse_done();
        idle = t + TMO;
      end
    endcase
    goto(idle - 1);
    @(negedge clk_in);
    check("active_before_idle", active_out, 1'b1);
    goto(idle);
  endtask

  // Accept a legal frame, then reset either in GUARD or in WAIT_DONE.
  task automatic reset_test(input bit in_wait_done);
    int          c, t;
    logic [39:0] d;
    req0_valid_in = 1'b0; req1_valid_in = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    d = rand_data();
    req0_valid_in = 1'b1; req0_data_in = d; req0_num_bytes_in = 3'd3;
    c = cyc;
    goto(c + 1);
    req0_valid_in = 1'b0;
    t = c + FDT + 1;
    if (!in_wait_done) begin
      goto(c + 2);
    end else begin
      exp_q.push_back('{kind: EV_TRIG, cyc: t, data: d, len: 3'd3, gid: 1'b0});
      goto(t + 1);
      pulse_busy();
      goto(t + 6);
    end
    req0_valid_in = 1'b1; req1_valid_in = 1'b1;
    #2 rst_in = 1'b1;
    #1;
    check_reset_outputs(in_wait_done ? "rst_wait_done" : "rst_guard");
    repeat (2) @(posedge clk_in);
    #1;
    req0_valid_in = 1'b0; req1_valid_in = 1'b0;
    rst_in   = 1'b0;
    last_gid = 1'b1;
    // Any trigger or error from the abandoned frame is caught by the monitor.
    goto(cyc + FDT + TMO + 5);
    @(negedge clk_in);
    check("active_after_reset", active_out, 1'b0);
    goto(cyc + 1);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    req0_valid_in = 1'b1; req0_data_in = rand_data(); req0_num_bytes_in = 3'd2;
    req1_valid_in = 1'b1; req1_data_in = rand_data(); req1_num_bytes_in = 3'd3;
    repeat (2) @(posedge clk_in);
    #1;
    check_reset_outputs("por");
    req0_valid_in = 1'b0; req1_valid_in = 1'b0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    goto(cyc + 1);

    // Directed frame from req0: trigger at cycle 5 after accept
    round(1'b1, 1'b0, 40'h0024906735, 3'd4, '0, '0, 0);

    // Illegal lengths from req1
    round(1'b0, 1'b1, '0, '0, rand_data(), 3'd0, 0);
    round(1'b0, 1'b1, '0, '0, rand_data(), 3'd7, 0);

    // Both requesters valid continuously: grants must alternate
    for (int i = 0; i < 4; i++)
      round(1'b1, 1'b1, rand_data(), 3'($urandom_range(1, 5)),
            rand_data(), 3'($urandom_range(1, 5)), $urandom_range(0, 1));

    // Timeout, done coinciding with timeout, done one cycle late
    round(1'b1, 1'b0, rand_data(), 3'd5, '0, '0, 2);
    round(1'b0, 1'b1, '0, '0, rand_data(), 3'd1, 3);
    round(1'b1, 1'b0, rand_data(), 3'd3, '0, '0, 4);

    // Reset mid-frame; after each the pointer must again favour req0
    reset_test(1'b0);
    round(1'b1, 1'b1, rand_data(), 3'd2, rand_data(), 3'd2, 1);
    reset_test(1'b1);
    round(1'b1, 1'b1, rand_data(), 3'd4, rand_data(), 3'd4, 0);

    // Randomised traffic
    for (int i = 0; i < 30; i++) begin
      logic w0, w1;
      w0 = 1'($urandom);
      w1 = 1'($urandom);
      if (!w0 && !w1 && !pend[0] && !pend[1]) w0 = 1'b1;
      round(w0, w1, rand_data(), rand_len(), rand_data(), rand_len(), $urandom_range(0, 4));
    end

    // Serve any request still held off, then let the pipeline settle
    while (pend[0] || pend[1])
      round(1'b0, 1'b0, '0, '0, '0, '0, 1);
    goto(cyc + 10);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
